// File: rtl/change_dispenser.sv
// Change-payout controller: greedy quarter/dime/nickel dispensing over a coin_valid/coin_ack hopper handshake.
// Optional ack timeout in ISSUE is enabled by defining CHANGE_ACK_TIMEOUT_EN.
module change_dispenser #(
  parameter int QUART_INIT  = 20,
  parameter int DIME_INIT   = 20,
  parameter int NICK_INIT   = 20,
  parameter int CNT_W       = 8,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req,
  input  logic [8:0]       amount,
  input  logic             refill,
  input  logic             coin_ack,
  output logic             coin_valid,
  output logic [1:0]       coin_sel,
  output logic             busy,
  output logic             done,
  output logic             short,
  output logic [8:0]       remaining,
  output logic [8:0]       quart,
  output logic [8:0]       dim,
  output logic [8:0]       nick,
  output logic [CNT_W-1:0] q_level,
  output logic [CNT_W-1:0] d_level,
  output logic [CNT_W-1:0] n_level,
  output logic             exact_change_only
);

  // state  | meaning
  // IDLE   | waiting for req; refill honoured here only
  // SELECT | greedy pick of the next coin, or finish
  // ISSUE  | coin_valid high, waiting for coin_ack
  // DONE   | one-cycle done/short pulse

  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, DONE} state_t;

  localparam logic [1:0] SEL_NONE = 2'b00;
  localparam logic [1:0] SEL_N    = 2'b01;
  localparam logic [1:0] SEL_D    = 2'b10;
  localparam logic [1:0] SEL_Q    = 2'b11;

  localparam logic [CNT_W-1:0] Q_FULL = CNT_W'(QUART_INIT);
  localparam logic [CNT_W-1:0] D_FULL = CNT_W'(DIME_INIT);
  localparam logic [CNT_W-1:0] N_FULL = CNT_W'(NICK_INIT);

  localparam int TO_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(ACK_TIMEOUT - 1);

`ifdef CHANGE_ACK_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  state_t          state;
  logic [1:0]      pick;
  logic [TO_W-1:0] ack_cnt;

  function automatic logic [8:0] coin_val(input logic [1:0] sel);
    case (sel)
      SEL_Q:   coin_val = 9'd25;
      SEL_D:   coin_val = 9'd10;
      SEL_N:   coin_val = 9'd5;
      default: coin_val = 9'd0;
    endcase
  endfunction

  // Greedy choice; a hopper at zero is never offered, so levels cannot underflow.
  always_comb begin
    pick = SEL_NONE;
    if (remaining >= 9'd25 && q_level != '0)
      pick = SEL_Q;
    else if (remaining >= 9'd10 && d_level != '0)
      pick = SEL_D;
    else if (remaining >= 9'd5 && n_level != '0)
      pick = SEL_N;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      coin_valid        <= 1'b0;
      coin_sel          <= SEL_NONE;
      busy              <= 1'b0;
      done              <= 1'b0;
      short             <= 1'b0;
      remaining         <= '0;
      quart             <= '0;
      dim               <= '0;
      nick              <= '0;
      q_level           <= Q_FULL;
      d_level           <= D_FULL;
      n_level           <= N_FULL;
      exact_change_only <= (N_FULL == '0);
      ack_cnt           <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            remaining <= amount;
            quart     <= '0;
            dim       <= '0;
            nick      <= '0;
            busy      <= 1'b1;
            state     <= SELECT;
          end else if (refill) begin
            q_level           <= Q_FULL;
            d_level           <= D_FULL;
            n_level           <= N_FULL;
            exact_change_only <= (N_FULL == '0);
          end
        end

        SELECT: begin
          if (pick != SEL_NONE) begin
            coin_sel   <= pick;
            coin_valid <= 1'b1;
            ack_cnt    <= TO_LOAD;
            state      <= ISSUE;
          end else begin
            done  <= 1'b1;
            short <= (remaining != '0);
            state <= DONE;
          end
        end

        ISSUE: begin
          if (coin_ack) begin
            coin_valid <= 1'b0;
            coin_sel   <= SEL_NONE;
            remaining  <= remaining - coin_val(coin_sel);
            case (coin_sel)
              SEL_Q: begin
                q_level <= q_level - 1'b1;
                quart   <= quart + 9'd1;
              end
              SEL_D: begin
                d_level <= d_level - 1'b1;
                dim     <= dim + 9'd1;
              end
              SEL_N: begin
                n_level           <= n_level - 1'b1;
                nick              <= nick + 9'd1;
                exact_change_only <= (n_level == CNT_W'(1));
              end
              default: ;
            endcase
            state <= SELECT;
          end else if (TIMEOUT_EN && ack_cnt == '0) begin
            // Hopper never answered: abandon the coin and report a shortfall.
            coin_valid <= 1'b0;
            coin_sel   <= SEL_NONE;
            done       <= 1'b1;
            short      <= 1'b1;
            state      <= DONE;
          end else if (ack_cnt != '0) begin
            ack_cnt <= ack_cnt - 1'b1;
          end
        end

        DONE: begin
          done  <= 1'b0;
          short <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Scoreboard bench for change_dispenser: stimulus pushes expected coins/results, monitors pop and compare.
module tb_change_dispenser;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       req = 1'b0, refill = 1'b0, coin_ack = 1'b0;
  logic [8:0] amount = '0;
  logic       coin_valid, busy, done, short, exact;
  logic [1:0] coin_sel;
  logic [8:0] remaining, quart, dim, nick;
  logic [7:0] q_level, d_level, n_level;

  logic       req2 = 1'b0, refill2 = 1'b0, coin_ack2 = 1'b0;
  logic [8:0] amount2 = '0;
  logic       coin_valid2, busy2, done2, short2, exact2;
  logic [1:0] coin_sel2;
  logic [8:0] remaining2, quart2, dim2, nick2;
  logic [7:0] q_level2, d_level2, n_level2;

  change_dispenser dut (
    .clk(clk), .rst(rst), .req(req), .amount(amount), .refill(refill), .coin_ack(coin_ack),
    .coin_valid(coin_valid), .coin_sel(coin_sel), .busy(busy), .done(done), .short(short),
    .remaining(remaining), .quart(quart), .dim(dim), .nick(nick),
    .q_level(q_level), .d_level(d_level), .n_level(n_level), .exact_change_only(exact)
  );

  change_dispenser #(.QUART_INIT(1), .DIME_INIT(3), .NICK_INIT(0)) dut2 (
    .clk(clk), .rst(rst), .req(req2), .amount(amount2), .refill(refill2), .coin_ack(coin_ack2),
    .coin_valid(coin_valid2), .coin_sel(coin_sel2), .busy(busy2), .done(done2), .short(short2),
    .remaining(remaining2), .quart(quart2), .dim(dim2), .nick(nick2),
    .q_level(q_level2), .d_level(d_level2), .n_level(n_level2), .exact_change_only(exact2)
  );

  typedef struct {
    bit sh;
    int rem, q, d, n, ql, dl, nl, cyc;
  } res_t;

  res_t res_q[$], res2_q[$];
  int   coin_q[$], coin2_q[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;
  int   ack_delay = 0;
  bit   ack_en = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Hopper model: acks after ack_delay extra ISSUE cycles; dut2 hopper always acks at once.
  initial begin
    int hold;
    hold = 0;
    forever begin
      @(negedge clk);
      if (coin_valid) begin
        coin_ack = ack_en && (hold >= ack_delay);
        hold++;
      end else begin
        coin_ack = 1'b0;
        hold = 0;
      end
      coin_ack2 = coin_valid2;
    end
  end

  initial begin
    bit   cv_prev;
    res_t r;
    cv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (coin_valid && !cv_prev) begin
        if (coin_q.size() == 0) chk("coin_extra", coin_q.size(), 1);
        else chk("coin_sel", int'(coin_sel), coin_q.pop_front());
      end
      cv_prev = coin_valid;
      if (done) begin
        if (res_q.size() == 0) chk("done_extra", res_q.size(), 1);
        else begin
          r = res_q.pop_front();
          chk("short", short, r.sh);
          chk("remaining", remaining, r.rem);
          chk("quart", quart, r.q);
          chk("dim", dim, r.d);
          chk("nick", nick, r.n);
          chk("q_level", q_level, r.ql);
          chk("d_level", d_level, r.dl);
          chk("n_level", n_level, r.nl);
          chk("exact_at_done", exact, (r.nl == 0) ? 1 : 0);
          if (r.cyc >= 0) chk("done_cycle", cyc, r.cyc);
        end
      end
    end
  end

  initial begin
    bit   cv_prev;
    res_t r;
    cv_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (busy2) chk("exact2_busy", exact2, 1);
      if (coin_valid2 && !cv_prev) begin
        if (coin2_q.size() == 0) chk("coin2_extra", coin2_q.size(), 1);
        else chk("coin2_sel", int'(coin_sel2), coin2_q.pop_front());
      end
      cv_prev = coin_valid2;
      if (done2) begin
        if (res2_q.size() == 0) chk("done2_extra", res2_q.size(), 1);
        else begin
          r = res2_q.pop_front();
          chk("short2", short2, r.sh);
          chk("remaining2", remaining2, r.rem);
          chk("quart2", quart2, r.q);
          chk("dim2", dim2, r.d);
          chk("nick2", nick2, r.n);
          chk("q_level2", q_level2, r.ql);
          chk("d_level2", d_level2, r.dl);
          chk("n_level2", n_level2, r.nl);
          if (r.cyc >= 0) chk("done2_cycle", cyc, r.cyc);
        end
      end
    end
  end

  // lat: cycle of done counted from the req edge (req at edge n -> done in cycle n+lat); -1 skips it.
  task automatic do_req(input int amt, input logic [5:0] seq, input int nc, input bit sh,
                        input int rem, input int q, input int d, input int n,
                        input int ql, input int dl, input int nl, input int lat);
    res_t r;
    int   n0;
    req    = 1'b1;
    amount = amt[8:0];
    @(posedge clk); #1;
    req = 1'b0;
    n0  = cyc;
    chk("busy_after_req", busy, 1);
    chk("cv_in_select", coin_valid, 0);
    for (int i = 0; i < nc; i++) coin_q.push_back(int'(seq[5-2*i -: 2]));
    r.sh = sh; r.rem = rem; r.q = q; r.d = d; r.n = n;
    r.ql = ql; r.dl = dl; r.nl = nl;
    r.cyc = (lat < 0) ? -1 : n0 + lat - 1;
    res_q.push_back(r);
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_reached", busy, 0);
    chk("res_q_drained", res_q.size(), 0);
    chk("coin_q_drained", coin_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r2;
    int   n0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("rst_q_level", q_level, 20);
    chk("rst_d_level", d_level, 20);
    chk("rst_n_level", n_level, 20);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_exact", exact, 0);
    chk("rst_coin_valid", coin_valid, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst2_levels", {16'(q_level2), 8'(d_level2), 8'(n_level2)}, {16'd1, 8'd3, 8'd0});
    chk("rst2_exact", exact2, 1);
    @(posedge clk); #1;

    do_req(40, 6'b111001, 3, 1'b0, 0, 1, 1, 1, 19, 19, 19, 8);
    wait_idle(100);

    do_req(0, 6'b000000, 0, 1'b0, 0, 0, 0, 0, 19, 19, 19, 2);
    wait_idle(100);

    do_req(47, 6'b111010, 3, 1'b1, 2, 1, 2, 0, 18, 17, 19, 8);
    wait_idle(100);

    // req/refill while busy must be ignored; slow hopper keeps ISSUE open
    ack_delay = 3;
    do_req(40, 6'b111001, 3, 1'b0, 0, 1, 1, 1, 17, 16, 18, 17);
    @(posedge clk); #1;
    chk("cv_in_issue", coin_valid, 1);
    req = 1'b1; amount = 9'd95; refill = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; refill = 1'b0; amount = '0;
    wait_idle(200);
    ack_delay = 0;

    // req wins over simultaneous refill
    refill = 1'b1;
    do_req(5, 6'b010000, 1, 1'b0, 0, 0, 0, 1, 17, 16, 17, 4);
    refill = 1'b0;
    wait_idle(100);

    refill = 1'b1;
    @(posedge clk); #1;
    refill = 1'b0;
    chk("refill_q", q_level, 20);
    chk("refill_d", d_level, 20);
    chk("refill_n", n_level, 20);
    chk("refill_busy", busy, 0);

    // shortfall instance: 1 quarter, 3 dimes, no nickels
    req2 = 1'b1; amount2 = 9'd30;
    @(posedge clk); #1;
    req2 = 1'b0;
    n0 = cyc;
    coin2_q.push_back(3);
    r2.sh = 1'b1; r2.rem = 5; r2.q = 1; r2.d = 0; r2.n = 0;
    r2.ql = 0; r2.dl = 3; r2.nl = 0; r2.cyc = n0 + 3;
    res2_q.push_back(r2);
    for (int i = 0; i < 100 && busy2; i++) begin
      @(posedge clk); #1;
    end
    chk("idle2_reached", busy2, 0);
    chk("res2_q_drained", res2_q.size(), 0);
    chk("coin2_q_drained", coin2_q.size(), 0);
    chk("exact2_after", exact2, 1);

`ifdef CHANGE_ACK_TIMEOUT_EN
    ack_en = 1'b0;
    do_req(25, 6'b110000, 1, 1'b1, 25, 0, 0, 0, 20, 20, 20, 17);
    wait_idle(100);
    ack_en = 1'b1;
`endif

    // asynchronous reset in the middle of ISSUE
    ack_en = 1'b0;
    req = 1'b1; amount = 9'd25;
    @(posedge clk); #1;
    req = 1'b0;
    coin_q.push_back(3);
    repeat (2) @(posedge clk);
    #1 chk("cv_before_rst", coin_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_cv", coin_valid, 0);
    chk("mid_rst_sel", coin_sel, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_short", short, 0);
    chk("mid_rst_remaining", remaining, 0);
    chk("mid_rst_quart", quart, 0);
    chk("mid_rst_q_level", q_level, 20);
    chk("mid_rst_exact", exact, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    ack_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_busy", busy, 0);
    chk("post_rst_coin_q", coin_q.size(), 0);
    chk("post_rst_res_q", res_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Change-payout controller for the vending machine. It takes a change amount in cents and dispenses it as quarters, dimes and nickels, one coin at a time, over a valid/ack handshake with the coin hopper mechanism. It tracks per-denomination hopper inventory and reports a shortfall when the hoppers cannot cover the amount. It sits between the vending_machine transaction logic, which requests payout, and the physical hopper driver.

## Interface
- `QUART_INIT`, 20, quarter hopper level after reset/refill
- `DIME_INIT`, 20, dime hopper level after reset/refill
- `NICK_INIT`, 20, nickel hopper level after reset/refill
- `CNT_W`, 8, hopper level counter width
- `ACK_TIMEOUT`, 15, cycles to wait for `coin_ack` (used only with the macro)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `req`  in  1  start payout; sampled in IDLE only
- `amount`  in  9  change in cents, latched on accepted `req`
- `refill`  in  1  restore all levels to `*_INIT`; honoured in IDLE only
- `coin_ack`  in  1  hopper has ejected the coin on `coin_sel`
- `coin_valid`  out  1  coin request to hopper
- `coin_sel`  out  2  00 none, 01 nickel, 10 dime, 11 quarter
- `busy`  out  1  state != IDLE
- `done`  out  1  high for the single DONE cycle
- `short`  out  1  valid with `done`: `remaining != 0`
- `remaining`  out  9  cents still owed
- `quart`, `dim`, `nick`  out  9 each  coins dispensed this transaction
- `q_level`, `d_level`, `n_level`  out  CNT_W each  hopper inventory
- `exact_change_only`  out  1  `n_level == 0`

## Operation
- FSM states: IDLE, SELECT, ISSUE, DONE.
- **IDLE**
  - On `req`: `remaining <= amount`, clear `quart`, `dim` and `nick`, then go to SELECT.
  - If `req` and `refill` arrive together, `req` wins and `refill` is dropped.
  - `req` and `refill` are ignored in all states other than IDLE.
- **SELECT** (greedy, no backtracking)
  - If `remaining >= 25` and `q_level > 0`: select quarter.
  - Else if `remaining >= 10` and `d_level > 0`: select dime.
  - Else if `remaining >= 5` and `n_level > 0`: select nickel.
  - Else go to DONE.
  - When a coin is selected, latch `coin_sel` and go to ISSUE.
- **ISSUE**
  - `coin_valid = 1`; `coin_sel` is held stable.
  - On `coin_ack`: decrement that hopper level, subtract the coin value from `remaining`, increment the matching `quart`/`dim`/`nick` counter, then go to SELECT.
- **DONE**
  - `done = 1` and `short = (remaining != 0)`, then go to IDLE.
  - `remaining`, `quart`, `dim` and `nick` hold their values until the next accepted `req`.
- Arithmetic and boundary rules:
  - All subtraction is unsigned. SELECT guards guarantee that `remaining` and the levels never underflow.
  - A level saturates at 0 and is never selected at 0.
  - An amount that is not a multiple of 5 leaves a residue of 1–4 in `remaining`, so `short = 1`.
  - `amount = 0` completes with `short = 0` and no coins.
  - `coin_ack` outside ISSUE is ignored.
- Reset (asynchronous, any state, including mid-ISSUE)
  - State returns to IDLE.
  - All outputs go to 0, except `q_level`/`d_level`/`n_level`, which load `*_INIT`, and `exact_change_only`, which becomes `(NICK_INIT == 0)`.
  - A coin in flight is abandoned and not counted.

## Timing
- `req` is sampled at edge n. SELECT occupies cycle n+1, with `busy` high from n+1.
- The first `coin_valid` is in cycle n+2.
- `coin_ack` is sampled at the edge ending an ISSUE cycle. Counters update on that same edge.
- `coin_valid` is low for exactly one cycle (SELECT) between consecutive coins.
- Minimum per-coin cost: 2 cycles (SELECT plus one ISSUE cycle when acked immediately).
- Example, 40 cents with immediate acks: ISSUE in cycles n+2, n+4 and n+6; DONE in n+8.
- `done`/`short` last one cycle, and `busy` falls in the cycle after DONE.

## Configuration
- `CHANGE_ACK_TIMEOUT_EN` defined:
  - ISSUE runs a cycle counter, cleared on entry.
  - If `coin_ack` is still absent after `ACK_TIMEOUT` cycles in ISSUE, go to DONE.
  - The pending coin is not counted, `remaining` and levels are unchanged, and `short = 1`.
- Not defined: ISSUE waits for `coin_ack` indefinitely, and `ACK_TIMEOUT` is unused.

## Test plan
- **Reset with defaults**
  - Response: `q_level`/`d_level`/`n_level` = 20/20/20, `busy` = 0, `done` = 0, `exact_change_only` = 0, `coin_valid` = 0.
- **Normal payout**: `amount` = 40, ack every ISSUE cycle.
  - `coin_sel` sequence 11, 10, 01.
  - `quart`/`dim`/`nick` = 1/1/1, `done` at n+8 with `short` = 0, `remaining` = 0.
  - Levels 19/19/19.
- **Greedy shortfall**: `QUART_INIT` = 1, `DIME_INIT` = 3, `NICK_INIT` = 0, `amount` = 30.
  - One quarter dispensed, then `done` with `short` = 1, `remaining` = 5.
  - `exact_change_only` = 1 throughout.
- **Zero amount**: `amount` = 0 at edge n.
  - No `coin_valid`; `done` = 1 in cycle n+2 with `short` = 0.
- **Ignored inputs while busy, then refill**
  - `req` with `amount` = 95 while busy is ignored: the current transaction completes unchanged.
  - `refill` during ISSUE has no effect.
  - `refill` in IDLE restores levels to 20/20/20.
- **Timeout** (`CHANGE_ACK_TIMEOUT_EN` defined): `amount` = 25, `coin_ack` never asserted.
  - `done` with `short` = 1 after 15 ISSUE cycles, `remaining` = 25, `q_level` = 20.
  - Assert `rst` mid-ISSUE in a second run: immediate return to IDLE with all outputs at reset values.
